mem_access_ctrl: RTL and testbench

- Initiator-side sequencer that sits between the CPU load/store stage and the 256-byte data memory with memory-mapped IO.
- Accepts one word (16-bit) or byte access per request over a valid/ready handshake.
- Drives the memory's address, read-enable, write-enable and write-data strobes, and captures read data.
- Rejects illegal accesses (read-only IO window, address wrap) and performs read-modify-write for byte stores, because the memory always writes two bytes.

---
 rtl/mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sits between the CPU load/store stage and a 256-byte data memory that
//   has memory-mapped IO. It accepts one word or byte access per valid/ready
//   handshake and drives the memory strobes. Accesses that would write the
//   read-only IO window, and word accesses that would wrap past 8'hFF, are
//   rejected. The memory always writes two bytes, so byte stores use a
//   read-modify-write.
//
//   Optional feature macro: BYTE_STORE_EN
//     defined   : byte stores run the RMW_RD / RMW_WR sequence
//     undefined : RMW states are not built; every byte store faults
//
//   Ports
//     i_clk, i_rst            clock, synchronous active-high reset
//     i_req_valid/o_req_ready request handshake (ready decoded from state)
//     i_req_write, i_req_byte store / byte-access qualifiers
//     i_req_addr, i_req_wdata byte address and store data
//     o_resp_valid            one-cycle completion pulse
//     o_resp_rdata            load data (zero for stores and faults)
//     o_resp_fault            access rejected, no memory write happened
//     o_mem_address, o_mem_read_en, o_mem_write_en, o_mem_wdata  to memory
//     i_mem_rdata             combinational read data from memory
module mem_access_ctrl #(
    parameter logic [7:0] RO_LO = 8'h4E,
    parameter logic [7:0] RO_HI = 8'h51
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic        i_req_byte,
    input  logic [7:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [15:0] o_resp_rdata,
    output logic        o_resp_fault,
    output logic [7:0]  o_mem_address,
    output logic        o_mem_read_en,
    output logic        o_mem_write_en,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FAULT  = 3'd1,
        S_RD     = 3'd2,
        S_WR     = 3'd3,
`ifdef BYTE_STORE_EN
        S_RMW_RD = 3'd4,
        S_RMW_WR = 3'd5,
`endif
        S_RESP   = 3'd6
    } state_t;

    function automatic logic in_ro(input logic [AW-1:0] a);
        return (a >= RO_LO) && (a <= RO_HI);
    endfunction

    state_t          r_state;
    logic            r_byte;      // latched request is a byte access
    logic            r_lo;        // byte target is the low byte of the word
`ifdef BYTE_STORE_EN
    logic [BW-1:0]   r_wbyte;     // byte to merge during RMW
`endif
    logic [AW-1:0]   r_mem_address;
    logic            r_mem_read_en;
    logic            r_mem_write_en;
    logic [DW-1:0]   r_mem_wdata;
    logic            r_resp_valid;
    logic [DW-1:0]   r_resp_rdata;
    logic            r_resp_fault;

    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_fault;
    logic            w_lo;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_addr_p1;
    logic [DW-1:0]   w_rd_data;
    logic [AW-1:0]   w_mem_address_nxt;
    logic            w_mem_read_en_nxt;
    logic            w_mem_write_en_nxt;
    logic [DW-1:0]   w_mem_wdata_nxt;
    logic            w_resp_valid_nxt;
    logic [DW-1:0]   w_resp_rdata_nxt;
    logic            w_resp_fault_nxt;

    assign o_req_ready    = (r_state == S_IDLE) && !i_rst;
    assign o_mem_address  = r_mem_address;
    assign o_mem_read_en  = r_mem_read_en;
    assign o_mem_write_en = r_mem_write_en;
    assign o_mem_wdata    = r_mem_wdata;
    assign o_resp_valid   = r_resp_valid;
    assign o_resp_rdata   = r_resp_rdata;
    assign o_resp_fault   = r_resp_fault;

    // Request decode: byte at 8'hFF is served from the word at 8'hFE (low byte)
    always_comb begin
        w_addr_p1 = AW'(i_req_addr + AW'(1));
        w_lo      = i_req_byte && (i_req_addr == '1);
        w_base    = w_lo ? AW'(8'hFE) : i_req_addr;
        w_fault   = (!i_req_byte && (i_req_addr == '1))
                  || (i_req_write && !i_req_byte && (in_ro(i_req_addr) || in_ro(w_addr_p1)))
                  || (i_req_write && i_req_byte && in_ro(i_req_addr));
`ifndef BYTE_STORE_EN
        if (i_req_write && i_req_byte) begin
            w_fault = 1'b1;
        end
`endif
    end

    // Load data selection: byte loads return the target byte zero-extended
    always_comb begin
        if (r_byte) begin
            w_rd_data = {BW'(0), (r_lo ? i_mem_rdata[BW-1:0] : i_mem_rdata[DW-1:BW])};
        end else begin
            w_rd_data = i_mem_rdata;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        w_state_nxt        = r_state;
        w_accept           = 1'b0;
        w_mem_address_nxt  = r_mem_address;
        w_mem_read_en_nxt  = 1'b0;
        w_mem_write_en_nxt = 1'b0;
        w_mem_wdata_nxt    = r_mem_wdata;
        w_resp_valid_nxt   = 1'b0;
        w_resp_rdata_nxt   = '0;
        w_resp_fault_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_accept = 1'b1;
                    if (w_fault) begin
                        w_state_nxt = S_FAULT;
                    end else if (!i_req_write) begin
                        w_state_nxt       = S_RD;
                        w_mem_read_en_nxt = 1'b1;
                        w_mem_address_nxt = w_base;
                    end else if (!i_req_byte) begin
                        w_state_nxt        = S_WR;
                        w_mem_write_en_nxt = 1'b1;
                        w_mem_address_nxt  = w_base;
                        w_mem_wdata_nxt    = i_req_wdata;
                    end else begin
`ifdef BYTE_STORE_EN
                        w_state_nxt       = S_RMW_RD;
                        w_mem_read_en_nxt = 1'b1;
                        w_mem_address_nxt = w_base;
`else
                        w_state_nxt = S_FAULT;
`endif
                    end
                end
            end
            S_FAULT: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_fault_nxt = 1'b1;
            end
            S_RD: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = w_rd_data;
            end
            S_WR: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
            end
`ifdef BYTE_STORE_EN
            S_RMW_RD: begin
                // Address is held; only the target byte of the read word changes
                w_state_nxt        = S_RMW_WR;
                w_mem_write_en_nxt = 1'b1;
                w_mem_wdata_nxt    = r_lo ? {i_mem_rdata[DW-1:BW], r_wbyte}
                                          : {r_wbyte, i_mem_rdata[BW-1:0]};
            end
            S_RMW_WR: begin
                w_state_nxt      = S_RESP;
                w_resp_valid_nxt = 1'b1;
            end
`endif
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, request latch and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_byte         <= 1'b0;
            r_lo           <= 1'b0;
`ifdef BYTE_STORE_EN
            r_wbyte        <= '0;
`endif
            r_mem_address  <= '0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_mem_wdata    <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_fault   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            if (w_accept) begin
                r_byte  <= i_req_byte;
                r_lo    <= w_lo;
`ifdef BYTE_STORE_EN
                r_wbyte <= i_req_wdata[BW-1:0];
`endif
            end
            r_mem_address  <= w_mem_address_nxt;
            r_mem_read_en  <= w_mem_read_en_nxt;
            r_mem_write_en <= w_mem_write_en_nxt;
            r_mem_wdata    <= w_mem_wdata_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
            r_resp_rdata   <= w_resp_rdata_nxt;
            r_resp_fault   <= w_resp_fault_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random accesses against a transaction model.
module tb_mem_access_ctrl;

`ifdef BYTE_STORE_EN
    localparam bit BSE = 1'b1;
`else
    localparam bit BSE = 1'b0;
`endif

    typedef struct {
        logic        w;
        logic        b;
        logic [7:0]  a;
        logic [15:0] d;
        logic        fault;
        logic [15:0] rdata;
        int          lat;
        int          nrd;
        logic [7:0]  rd_addr;
        int          rd_cyc;
        int          nwr;
        logic [7:0]  wr_addr;
        logic [15:0] wr_data;
        int          wr_cyc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_fault;
    logic [7:0]  mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        pre_we;
    logic [7:0]  pre_a;
    logic [7:0]  pre_d;

    int n_vec;
    int n_err;

    mem_access_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_write    (req_write),
        .i_req_byte     (req_byte),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_fault   (resp_fault),
        .o_mem_address  (mem_address),
        .o_mem_read_en  (mem_read_en),
        .o_mem_write_en (mem_write_en),
        .o_mem_wdata    (mem_wdata),
        .i_mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian two-byte memory, preloadable while the DUT is in reset
    assign mem_rdata = {mem[mem_address], mem[8'(mem_address + 8'd1)]};
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (mem_write_en) begin
            mem[mem_address]               <= mem_wdata[15:8];
            mem[8'(mem_address + 8'd1)]    <= mem_wdata[7:0];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit ro(input logic [7:0] a);
        return (a >= 8'h4E) && (a <= 8'h51);
    endfunction

    // Transaction-level reference: outcome of one access and its memory effect
    function automatic vec_t model(input logic w, input logic b, input logic [7:0] a,
                                   input logic [15:0] d);
        vec_t        e;
        logic [7:0]  base;
        logic [7:0]  a1;
        bit          flt;
        e = '{default: 0};
        e.w = w; e.b = b; e.a = a; e.d = d;
        a1   = 8'(a + 8'd1);
        base = (b && a == 8'hFF) ? 8'hFE : a;
        flt  = (!b && a == 8'hFF) || (w && !b && (ro(a) || ro(a1))) || (w && b && (ro(a) || !BSE));
        e.lat = 2;
        if (flt) begin
            e.fault = 1'b1;
        end else if (!w) begin
            e.nrd = 1; e.rd_addr = base; e.rd_cyc = 1;
            e.rdata = b ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[a1]};
        end else if (!b) begin
            e.nwr = 1; e.wr_addr = a; e.wr_data = d; e.wr_cyc = 1;
            ref_mem[a]  = d[15:8];
            ref_mem[a1] = d[7:0];
        end else begin
            ref_mem[a] = d[7:0];
            e.nrd = 1; e.rd_addr = base; e.rd_cyc = 1;
            e.nwr = 1; e.wr_addr = base; e.wr_cyc = 2;
            e.wr_data = {ref_mem[base], ref_mem[8'(base + 8'd1)]};
            e.lat = 3;
        end
        return e;
    endfunction

    // Issue one request (entered at a negedge) and observe it until resp_valid
    task automatic run_req(input logic w, input logic b, input logic [7:0] a,
                           input logic [15:0] d, output vec_t o);
        int k;
        o = '{default: 0};
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            chk("strobe_exclusive", 32'(mem_read_en & mem_write_en), 32'd0);
            if (mem_read_en) begin
                o.nrd++; o.rd_addr = mem_address; o.rd_cyc = c;
            end
            if (mem_write_en) begin
                o.nwr++; o.wr_addr = mem_address; o.wr_data = mem_wdata; o.wr_cyc = c;
            end
            if (resp_valid) begin
                o.lat = c; o.fault = resp_fault; o.rdata = resp_rdata;
                break;
            end
        end
    endtask

    task automatic cmp(input string tag, input vec_t e, input vec_t o);
        chk({tag, ".fault"}, 32'(o.fault), 32'(e.fault));
        chk({tag, ".rdata"}, 32'(o.rdata), 32'(e.rdata));
        chk({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
        chk({tag, ".n_read"}, 32'(o.nrd), 32'(e.nrd));
        chk({tag, ".n_write"}, 32'(o.nwr), 32'(e.nwr));
        if (e.nrd != 0) begin
            chk({tag, ".rd_addr"}, 32'(o.rd_addr), 32'(e.rd_addr));
            chk({tag, ".rd_cyc"}, 32'(o.rd_cyc), 32'(e.rd_cyc));
        end
        if (e.nwr != 0) begin
            chk({tag, ".wr_addr"}, 32'(o.wr_addr), 32'(e.wr_addr));
            chk({tag, ".wr_data"}, 32'(o.wr_data), 32'(e.wr_data));
            chk({tag, ".wr_cyc"}, 32'(o.wr_cyc), 32'(e.wr_cyc));
        end
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        obs;
        vec_t        e;
        logic [7:0]  bl [10];
        logic [7:0]  v;
        logic        w;
        logic        b;
        logic [7:0]  a;
        logic [15:0] d;

        n_vec = 0; n_err = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        req_addr = 8'h00; req_wdata = 16'h0000;
        pre_we = 1'b0; pre_a = 8'h00; pre_d = 8'h00;

        // Preload memory during reset
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            case (i)
                8'h20:   v = 8'h11;
                8'h21:   v = 8'h22;
                8'h30:   v = 8'h77;
                8'h31:   v = 8'h88;
                8'h4E:   v = 8'hBE;
                8'h4F:   v = 8'hEF;
                8'hFE:   v = 8'hAB;
                8'hFF:   v = 8'hCD;
                default: v = 8'($urandom);
            endcase
            pre_we = 1'b1; pre_a = 8'(i); pre_d = v;
            ref_mem[i] = v;
        end
        @(negedge clk);
        pre_we = 1'b0;
        @(negedge clk);

        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.mem_read_en", 32'(mem_read_en), 32'd0);
        chk("rst.mem_write_en", 32'(mem_write_en), 32'd0);
        chk("rst.mem_address", 32'(mem_address), 32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_fault", 32'(resp_fault), 32'd0);
        chk("rst.resp_rdata", 32'(resp_rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.req_ready", 32'(req_ready), 32'd1);

        // Directed vectors: {w,b,a,d, fault,rdata,lat, nrd,rd_addr,rd_cyc, nwr,wr_addr,wr_data,wr_cyc}
        tbl.push_back('{1,0,8'h40,16'h1234, 0,16'h0000,2, 0,8'h00,0, 1,8'h40,16'h1234,1});
        tbl.push_back('{0,0,8'h40,16'h0000, 0,16'h1234,2, 1,8'h40,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{1,0,8'h4D,16'hDEAD, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
        tbl.push_back('{1,0,8'h4F,16'hBEAD, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
        tbl.push_back('{1,0,8'h51,16'h1111, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
        tbl.push_back('{1,0,8'h4C,16'h5566, 0,16'h0000,2, 0,8'h00,0, 1,8'h4C,16'h5566,1});
        tbl.push_back('{0,0,8'h4C,16'h0000, 0,16'h5566,2, 1,8'h4C,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,0,8'h4D,16'h0000, 0,16'h66BE,2, 1,8'h4D,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,0,8'hFF,16'h0000, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,1,8'hFF,16'h0000, 0,16'h00CD,2, 1,8'hFE,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,1,8'h41,16'h0000, 0,16'h0034,2, 1,8'h41,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,0,8'h4E,16'h0000, 0,16'hBEEF,2, 1,8'h4E,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{0,1,8'h4E,16'h0000, 0,16'h00BE,2, 1,8'h4E,1, 0,8'h00,16'h0000,0});
        tbl.push_back('{1,1,8'h4E,16'h00AA, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
        if (BSE) begin
            tbl.push_back('{1,1,8'h20,16'h00EE, 0,16'h0000,3, 1,8'h20,1, 1,8'h20,16'hEE22,2});
            tbl.push_back('{0,0,8'h20,16'h0000, 0,16'hEE22,2, 1,8'h20,1, 0,8'h00,16'h0000,0});
            tbl.push_back('{1,1,8'hFF,16'h0077, 0,16'h0000,3, 1,8'hFE,1, 1,8'hFE,16'hAB77,2});
            tbl.push_back('{0,0,8'hFE,16'h0000, 0,16'hAB77,2, 1,8'hFE,1, 0,8'h00,16'h0000,0});
        end else begin
            tbl.push_back('{1,1,8'h20,16'h00EE, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
            tbl.push_back('{0,0,8'h20,16'h0000, 0,16'h1122,2, 1,8'h20,1, 0,8'h00,16'h0000,0});
            tbl.push_back('{1,1,8'hFF,16'h0077, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});
            tbl.push_back('{0,0,8'hFE,16'h0000, 0,16'hABCD,2, 1,8'hFE,1, 0,8'h00,16'h0000,0});
        end
        tbl.push_back('{1,0,8'hFE,16'h0102, 0,16'h0000,2, 0,8'h00,0, 1,8'hFE,16'h0102,1});
        tbl.push_back('{1,0,8'hFF,16'h0304, 1,16'h0000,2, 0,8'h00,0, 0,8'h00,16'h0000,0});

        foreach (tbl[i]) begin
            e = model(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d);
            run_req(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, obs);
            cmp($sformatf("vec%0d", i), tbl[i], obs);
        end

        // req_valid held high across a store: second accept only after RESP
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
        req_addr = 8'h60; req_wdata = 16'hA5A5;
        @(negedge clk);
        chk("hold.c1.ready", 32'(req_ready), 32'd0);
        chk("hold.c1.wr_en", 32'(mem_write_en), 32'd1);
        chk("hold.c1.addr", 32'(mem_address), 32'h60);
        @(negedge clk);
        chk("hold.c2.ready", 32'(req_ready), 32'd0);
        chk("hold.c2.resp_valid", 32'(resp_valid), 32'd1);
        chk("hold.c2.fault", 32'(resp_fault), 32'd0);
        @(negedge clk);
        chk("hold.c3.ready", 32'(req_ready), 32'd1);
        chk("hold.c3.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold.second.wr_en", 32'(mem_write_en), 32'd1);
        @(negedge clk);
        chk("hold.second.resp_valid", 32'(resp_valid), 32'd1);
        e = model(1'b1, 1'b0, 8'h60, 16'hA5A5);
        e = model(1'b1, 1'b0, 8'h60, 16'hA5A5);

        // Reset asserted in the first cycle after a byte-store accept
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
        req_addr = 8'h30; req_wdata = 16'h00EE;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid.rd_en", 32'(mem_read_en), 32'(BSE));
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid.rd_en_drop", 32'(mem_read_en), 32'd0);
        chk("rstmid.wr_en", 32'(mem_write_en), 32'd0);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid.ready_in_rst", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) chk("rstmid.ready_after", 32'(req_ready), 32'd1);
            chk("rstmid.no_resp", 32'(resp_valid), 32'd0);
            chk("rstmid.no_write", 32'(mem_write_en), 32'd0);
        end
        chk("rstmid.mem30", 32'(mem[8'h30]), 32'h77);
        chk("rstmid.mem31", 32'(mem[8'h31]), 32'h88);

        // Random accesses, biased toward boundary addresses
        bl = '{8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50, 8'h51, 8'h52, 8'hFE, 8'hFF, 8'h00};
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? bl[$urandom_range(0, 9)] : 8'($urandom);
            d = 16'($urandom);
            e = model(w, b, a, d);
            run_req(w, b, a, d, obs);
            cmp($sformatf("rnd%0d", n), e, obs);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("mem[%0h]", i), 32'(mem[i]), 32'(ref_mem[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
